// File: rtl/corescore_arb_pkg.sv
// Shared types and helpers for the corescore stream arbiter.
//   arb_state_t : arbiter FSM state (IDLE / BUSY)
//   N_SRC_DEF, TIMEOUT_DEF : default parameter values
//   idx_w()     : index width for an N-entry vector (never below 1)
package corescore_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int N_SRC_DEF   = 4;
    localparam int TIMEOUT_DEF = 1024;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/corescore_rr_pick.sv
// Combinational round-robin picker.
// Searches req upward starting at last+1, wrapping at N, and returns the
// first set bit as a one-hot pick.
//   req   in  N   request vector
//   last  in  IW  index of the previous winner
//   pick  out N   one-hot winner (zero when no request)
//   valid out 1   any request present
module corescore_rr_pick
    import corescore_arb_pkg::*;
#(
    parameter int N  = N_SRC_DEF,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick,
    output logic          valid
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    logic          found;

    assign valid = |req;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            // one extra bit so last+i cannot overflow before the wrap
            sum = {1'b0, last} + (IW+1)'(i);
            if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/corescore_stream_arbiter.sv
// Packet-atomic round-robin arbiter: N_SRC byte AXI-stream sources share one
// byte-wide sink. The grant is held from the first beat to the tlast beat.
//   i_clk, i_rst           clock, asynchronous active-high reset
//   i_tdata/i_tlast/i_tvalid, o_tready   per-source stream (8 bits per source)
//   o_tdata/o_tlast/o_tvalid, i_tready   sink stream
//   o_grant    one-hot current grant, zero when idle
//   o_pkt_cnt  completed packets, wraps modulo 2^CNT_W
//   o_timeout  sticky forced-release flag
// Optional: define CORESCORE_ARB_TIMEOUT_EN to release a grant after TIMEOUT
// consecutive cycles with the granted source not valid.
module corescore_stream_arbiter
    import corescore_arb_pkg::*;
#(
    parameter int N_SRC   = N_SRC_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [8*N_SRC-1:0] i_tdata,
    input  logic [N_SRC-1:0]   i_tlast,
    input  logic [N_SRC-1:0]   i_tvalid,
    output logic [N_SRC-1:0]   o_tready,
    output logic [7:0]         o_tdata,
    output logic               o_tlast,
    output logic               o_tvalid,
    input  logic               i_tready,
    output logic [N_SRC-1:0]   o_grant,
    output logic [CNT_W-1:0]   o_pkt_cnt,
    output logic               o_timeout
);

    localparam int IW = idx_w(N_SRC);

    arb_state_t       state;
    logic [N_SRC-1:0] grant;
    logic [IW-1:0]    last;      // doubles as the granted index while BUSY
    logic [CNT_W-1:0] pkt_cnt;
    logic [N_SRC-1:0] pick;
    logic             pick_vld;
    logic [IW-1:0]    pick_idx;
    logic [7:0]       src_data [N_SRC];
    logic             beat, done, tmo_fire;

    for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
        assign src_data[k] = i_tdata[8*k +: 8];
    end

    corescore_rr_pick #(.N(N_SRC), .IW(IW)) u_pick (
        .req   (i_tvalid),
        .last  (last),
        .pick  (pick),
        .valid (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_SRC; i++)
            if (pick[i]) pick_idx = IW'(i);
    end

    // sink side is a pure pass-through of the granted source, gated by state
    always_comb begin
        o_tdata  = '0;
        o_tlast  = 1'b0;
        o_tvalid = 1'b0;
        o_tready = '0;
        if (state == BUSY) begin
            o_tdata        = src_data[last];
            o_tlast        = i_tlast[last];
            o_tvalid       = i_tvalid[last];
            o_tready[last] = i_tready;
        end
    end

    assign beat = (state == BUSY) && i_tvalid[last] && i_tready;
    assign done = beat && i_tlast[last];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            grant   <= '0;
            last    <= IW'(N_SRC - 1);
            pkt_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (pick_vld) begin
                    grant <= pick;
                    last  <= pick_idx;
                    state <= BUSY;
                end
                default: begin
                    if (done || tmo_fire) begin
                        grant <= '0;
                        state <= IDLE;
                    end
                    if (done) pkt_cnt <= pkt_cnt + 1'b1;
                end
            endcase
        end
    end

`ifdef CORESCORE_ARB_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);

    logic [SW-1:0] stall;
    logic          timeout_q;

    // fires on the TIMEOUT-th consecutive cycle with the granted source idle
    assign tmo_fire = (state == BUSY) && !i_tvalid[last] && (stall == SW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall     <= '0;
            timeout_q <= 1'b0;
        end else if (state != BUSY || i_tvalid[last]) begin
            stall <= '0;
        end else if (tmo_fire) begin
            stall     <= '0;
            timeout_q <= 1'b1;
        end else begin
            stall <= stall + 1'b1;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign tmo_fire  = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_grant   = grant;
    assign o_pkt_cnt = pkt_cnt;

endmodule

// File: tb/tb_corescore_stream_arbiter.sv
// Self-checking bench for corescore_stream_arbiter (N_SRC=4, CNT_W=4, TIMEOUT=8).
// A behavioural model of the arbitration rules predicts every output on every
// cycle; directed scenarios add literal expectations.
module tb_corescore_stream_arbiter;

    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [8*N-1:0] tdata = '0;
    logic [N-1:0]   tlast = '0;
    logic [N-1:0]   tvalid = '0;
    logic [N-1:0]   tready_o;
    logic [7:0]     odata;
    logic           olast, ovalid;
    logic           iready = 1'b1;
    logic [N-1:0]   grant;
    logic [CW-1:0]  cnt;
    logic           tmo;

    always #5 clk = ~clk;

    corescore_stream_arbiter #(.N_SRC(N), .TIMEOUT(TMO), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst), .i_tdata(tdata), .i_tlast(tlast),
        .i_tvalid(tvalid), .o_tready(tready_o), .o_tdata(odata),
        .o_tlast(olast), .o_tvalid(ovalid), .i_tready(iready),
        .o_grant(grant), .o_pkt_cnt(cnt), .o_timeout(tmo)
    );

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- source / sink stimulus ----------------
    logic [7:0] qd [N][$];
    bit         ql [N][$];
    int         vprob = 100;   // percent chance a source with data asserts valid
    int         rmode = 0;     // 0: sink always ready, 1: toggle, 2: random
    logic [N-1:0] acc = '0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            tvalid = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    void'(qd[k].pop_front());
                    void'(ql[k].pop_front());
                end
                if (!(tvalid[k] && !acc[k]))
                    tvalid[k] = (qd[k].size() > 0) && (int'($urandom_range(99)) < vprob);
                if (tvalid[k]) begin
                    tdata[8*k +: 8] = qd[k][0];
                    tlast[k]        = ql[k][0];
                end else begin
                    tdata[8*k +: 8] = 8'($urandom);
                    tlast[k]        = 1'($urandom);
                end
            end
            case (rmode)
                0:       iready = 1'b1;
                1:       iready = ~iready;
                default: iready = 1'($urandom);
            endcase
        end
    end

    // ---------------- behavioural model + monitors ----------------
    bit   m_busy = 0;
    int   m_g = 0, m_last = N - 1, m_cnt = 0, m_stall = 0;
    bit   m_tmo = 0;
    logic [7:0] rx [$];
    int   rx_pkts = 0;
    int   gorder [$];
    logic [N-1:0] prev_grant = '0;

    always @(negedge clk) begin
        logic [N-1:0] e_grant, e_ready;
        logic [7:0]   e_data;
        logic         e_last, e_valid;
        int           j;
        bit           found;

        if (rst) begin
            m_busy = 0; m_last = N - 1; m_cnt = 0; m_tmo = 0; m_stall = 0;
        end

        e_grant = m_busy ? N'(1 << m_g) : '0;
        e_data  = m_busy ? tdata[8*m_g +: 8] : 8'h00;
        e_last  = m_busy ? tlast[m_g] : 1'b0;
        e_valid = m_busy ? tvalid[m_g] : 1'b0;
        e_ready = (m_busy && iready) ? N'(1 << m_g) : '0;
        check("grant",   32'(grant),    32'(e_grant));
        check("tdata",   32'(odata),    32'(e_data));
        check("tlast",   32'(olast),    32'(e_last));
        check("tvalid",  32'(ovalid),   32'(e_valid));
        check("tready",  32'(tready_o), 32'(e_ready));
        check("pkt_cnt", 32'(cnt),      32'(m_cnt));
        check("timeout", 32'(tmo),      32'(m_tmo));

        acc = tvalid & tready_o;
        if (ovalid && iready) begin
            rx.push_back(odata);
            if (olast) rx_pkts++;
        end
        if (grant != '0 && prev_grant == '0) gorder.push_back($clog2(grant));
        prev_grant = grant;

        if (!rst) begin
            if (!m_busy) begin
                if (tvalid != '0) begin
                    found = 0;
                    for (int i = 1; i <= N; i++) begin
                        j = (m_last + i) % N;
                        if (!found && tvalid[j]) begin m_g = j; found = 1; end
                    end
                    m_last = m_g; m_busy = 1; m_stall = 0;
                end
            end else begin
                if (tvalid[m_g] && iready && tlast[m_g]) begin
                    m_busy = 0;
                    m_cnt  = (m_cnt + 1) % (1 << CW);
                end
`ifdef CORESCORE_ARB_TIMEOUT_EN
                else if (!tvalid[m_g]) begin
                    m_stall++;
                    if (m_stall == TMO) begin m_busy = 0; m_tmo = 1; m_stall = 0; end
                end else m_stall = 0;
`endif
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin qd[k].delete(); ql[k].delete(); end
        step(2);
        rx.delete(); gorder.delete(); rx_pkts = 0;
        rst = 1'b0;
        step(1);
    endtask

    task automatic push(input int src, input logic [7:0] d, input bit l);
        qd[src].push_back(d);
        ql[src].push_back(l);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int n;
        logic [7:0] exp4 [4];
        step(3);
        check("reset_grant", 32'(grant), 0);
        check("reset_cnt",   32'(cnt), 0);
        rst = 1'b0;
        step(1);

        // single source: src1 sends 41 42 43
        push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 1);
        step(1);
        check("single_req_idle", 32'(grant), 0);
        step(1);
        check("single_grant", 32'(grant), 32'h2);
        check("single_b0", 32'(odata), 32'h41);
        step(1);
        check("single_b1", 32'(odata), 32'h42);
        step(1);
        check("single_b2", 32'(odata), 32'h43);
        check("single_last", 32'(olast), 1);
        step(1);
        check("single_cnt", 32'(cnt), 1);
        check("single_release", 32'(grant), 0);

        // contention: all four sources, 2-byte packets
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < N; k++) begin
                push(k, 8'(k*16 + p*2), 0);
                push(k, 8'(k*16 + p*2 + 1), 1);
            end
        n = 0;
        while (rx_pkts < 6 && n < 100) begin step(1); n++; end
        check("contend_wait", 32'(n < 100), 1);
        step(1);
        check("contend_cnt", 32'(cnt), 6);
        check("contend_order_len", 32'(gorder.size() >= 6), 1);
        begin
            int ord [6] = '{0, 1, 2, 3, 0, 1};
            for (int i = 0; i < 6; i++) check("contend_order", 32'(gorder[i]), 32'(ord[i]));
        end

        // sink backpressure: toggling ready during a 4-byte packet
        do_reset();
        rmode = 1;
        exp4 = '{8'h10, 8'h11, 8'h12, 8'h13};
        for (int i = 0; i < 4; i++) push(2, exp4[i], i == 3);
        n = 0;
        while (rx_pkts < 1 && n < 50) begin step(1); n++; end
        check("bp_wait", 32'(n < 50), 1);
        check("bp_len", 32'(rx.size()), 4);
        for (int i = 0; i < 4; i++) check("bp_byte", 32'(rx[i]), 32'(exp4[i]));
        step(1);
        check("bp_cnt", 32'(cnt), 1);

        // mid-packet reset
        rmode = 0;
        rx.delete();
        for (int i = 0; i < 4; i++) push(0, 8'hA0 + 8'(i), i == 3);
        n = 0;
        while (rx.size() < 2 && n < 50) begin step(1); n++; end
        check("mid_wait", 32'(n < 50), 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(ovalid), 0);
        check("mid_rst_grant", 32'(grant), 0);
        check("mid_rst_cnt",   32'(cnt), 0);
        do_reset();
        push(3, 8'h33, 1); push(1, 8'h11, 1); push(0, 8'h00, 1);
        n = 0;
        while (gorder.size() < 1 && n < 20) begin step(1); n++; end
        check("post_rst_first", 32'(gorder[0]), 0);

        // counter wrap: 17 one-byte packets with CNT_W=4
        do_reset();
        for (int i = 0; i < 17; i++) push(int'($urandom_range(N-1)), 8'(i), 1);
        n = 0;
        while (rx_pkts < 17 && n < 300) begin step(1); n++; end
        check("wrap_wait", 32'(n < 300), 1);
        step(1);
        check("wrap_cnt", 32'(cnt), 1);

`ifdef CORESCORE_ARB_TIMEOUT_EN
        // forced release: src2 sends one non-final byte then stalls
        do_reset();
        push(2, 8'h55, 0); push(3, 8'h66, 1);
        step(2);
        check("tmo_grant", 32'(grant), 32'h4);
        n = 0;
        while (grant != '0 && n < 40) begin step(1); n++; end
        check("tmo_cycles", 32'(n), 9);
        check("tmo_flag", 32'(tmo), 1);
        check("tmo_cnt", 32'(cnt), 0);
        step(1);
        check("tmo_next", 32'(grant), 32'h8);
`endif

        // randomized traffic, model checks every cycle
        do_reset();
        rmode = 2;
        vprob = 70;
        for (int r = 0; r < 10; r++) begin
            for (int p = 0; p < 20; p++) begin
                int s, len;
                s   = int'($urandom_range(N-1));
                len = int'($urandom_range(4, 1));
                for (int b = 0; b < len; b++) push(s, 8'($urandom), b == len - 1);
            end
            step(int'($urandom_range(30)));
        end
        n = 0;
        while (rx_pkts < 200 && n < 20000) begin step(1); n++; end
        check("rand_drain", 32'(rx_pkts), 200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/corescore_stream_arbiter.md
Name: corescore_stream_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one byte-wide AXI-stream sink (the UART emitter) among N_SRC byte-stream sources, for example corescorecore result streams or a debug/status stream.
- Sits between the sources and the emitter in the board top level.
- Grant is held from the first accepted beat to the tlast beat, so packets are never interleaved.

Parameters:
- N_SRC, 4, number of requesting stream sources (2..16).
- TIMEOUT, 1024, stall cycles before forced release (used only with the optional feature).
- CNT_W, 16, width of the completed-packet counter.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous active-high reset.
- i_tdata  in  8*N_SRC  source data; source k occupies bits [8k+7:8k].
- i_tlast  in  N_SRC  per-source end-of-packet.
- i_tvalid  in  N_SRC  per-source valid.
- o_tready  out  N_SRC  per-source ready.
- o_tdata  out  8  data to sink.
- o_tlast  out  1  end-of-packet to sink.
- o_tvalid  out  1  valid to sink.
- i_tready  in  1  sink ready.
- o_grant  out  N_SRC  one-hot current grant, all zero when idle.
- o_pkt_cnt  out  CNT_W  completed packets, wraps modulo 2^CNT_W.
- o_timeout  out  1  sticky forced-release flag; tied 0 when the optional feature is off.

Behaviour:
- Reset is asynchronous active-high. While asserted and after release:
  - state = IDLE, o_grant = 0, o_pkt_cnt = 0, o_timeout = 0.
  - Round-robin pointer last = N_SRC-1, so source 0 has first priority.
  - o_tvalid, o_tready and o_tlast are 0 immediately, because they are gated by state.
- State IDLE:
  - o_tvalid = 0, o_tready = 0, o_tdata = 0.
  - If any i_tvalid is set, select the first set bit searching from last+1 upward with wrap-around.
  - Register the one-hot grant, set last to the selected index, go to BUSY.
  - Arbitration latency is exactly one cycle: a request seen in cycle t drives o_tvalid in cycle t+1.
- State BUSY, with g = granted index:
  - o_tdata = i_tdata[g], o_tlast = i_tlast[g], o_tvalid = i_tvalid[g]. This is a combinational pass-through with no added latency.
  - o_tready[g] = i_tready; all other o_tready bits are 0.
  - A beat transfers when i_tvalid[g] and i_tready are both high.
  - A beat with i_tlast[g] high: next state IDLE, o_grant cleared, o_pkt_cnt incremented.
  - Source g dropping tvalid mid-packet keeps the grant; there is no preemption.
- Every packet is followed by one IDLE bubble cycle. Back-to-back packets from the same source are therefore separated by one cycle.
- Fairness:
  - After source k completes a packet, every other requesting source is served before k again.
  - Maximum wait is (N_SRC-1) packets.
- Simultaneous events:
  - New requests arriving in the tlast cycle are not arbitrated until the following IDLE cycle.
  - Requests from non-granted sources never affect the outputs.
- o_pkt_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-packet abandons the packet. The sink sees o_tvalid fall without tlast; this is acceptable because the whole system resets together.

Optional Feature:
- Macro: CORESCORE_ARB_TIMEOUT_EN.
- With the macro defined:
  - In BUSY, a stall counter counts consecutive cycles with i_tvalid[g] = 0. It resets on any cycle with i_tvalid[g] = 1 and on entry to BUSY.
  - When the counter reaches TIMEOUT: go to IDLE, set o_timeout (sticky until reset), and do not increment o_pkt_cnt.
  - Sink stalls (i_tready = 0) do not count.
- Without the macro:
  - No counter is instantiated and o_timeout is constant 0.
  - A stalled source holds the grant indefinitely.

Decomposition:
- Package corescore_arb_pkg holds:
  - state enum {IDLE, BUSY};
  - default constants N_SRC_DEF = 4, TIMEOUT_DEF = 1024;
  - a function returning the index width, clog2(N_SRC).
- One sub-module, corescore_rr_pick: a purely combinational round-robin picker.
  - Inputs: request vector and last index.
  - Outputs: one-hot pick and a valid flag.
  - It is reusable by other arbiters in the design.

Test Plan:
- Single source: src1 sends 3 bytes 0x41, 0x42, 0x43 (tlast on 0x43) with sink always ready.
  - o_grant = 0010 one cycle after the request; o_tdata shows the 3 bytes on consecutive cycles.
  - o_pkt_cnt = 1, then o_grant = 0 in the next cycle.
- Contention: all 4 sources request continuously with 2-byte packets.
  - Grant order is 0, 1, 2, 3, 0, 1 with no interleaving within a packet.
  - o_pkt_cnt = 6 after 6 packets.
- Sink backpressure: i_tready toggles 1,0,1,0 during a 4-byte packet.
  - Each byte is held stable while i_tready = 0; all 4 bytes are delivered in order.
  - Only o_tready[g] follows i_tready.
- Mid-packet reset: assert i_rst after byte 2 of 4.
  - o_tvalid = 0, o_grant = 0 and o_pkt_cnt = 0 with no clock edge.
  - After release, source 0 wins if it requests alongside others.
- Wrap: CNT_W = 4, send 17 one-byte packets → o_pkt_cnt = 1.
- Timeout (macro on, TIMEOUT = 8): src2 sends 1 byte and then drops tvalid for 8 cycles.
  - Grant releases 8 cycles after the last beat; o_timeout = 1.
  - o_pkt_cnt is unchanged; a pending src3 is granted next.
